// File: rtl/cr_xp10_decomp_htf_symtab_seq.sv
// HTF symbol-table sequencer: drives the small-Huffman decoder and expands repeat codes into bit-length writes.
// Latency: bits_consume is combinational in the accept cycle; every write appears one cycle after its accept or REPEAT cycle.
// Backpressure: stalls with no consume while bits_valid_i is low; the REPEAT expansion stops the header stream until it finishes.
module cr_xp10_decomp_htf_symtab_seq #(
    parameter int BLW  = 5,
    parameter int IDXW = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            fmt_deflate_i,
    input  logic [IDXW-1:0] num_bl_i,
    input  logic            bits_valid_i,
    input  logic [15:0]     bits_data_i,
    input  logic [3:0]      dec_len_i,
    input  logic [BLW-1:0]  dec_bl_i,
    input  logic [IDXW-1:0] dec_base_i,
    input  logic [1:0]      dec_extra_i,
    input  logic            dec_prev_rep_i,
    input  logic            dec_err_i,
    output logic [4:0]      bits_consume_o,
    output logic [BLW-1:0]  prev_bl_o,
    output logic [BLW-1:0]  prev_nz_bl_o,
    output logic            bl_wr_en_o,
    output logic [IDXW-1:0] bl_wr_addr_o,
    output logic [BLW-1:0]  bl_wr_data_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    // count is one bit wider than an index; index+count gets one more so the
    // overflow compare can never wrap, even for a bogus decoder base.
    localparam int CW = IDXW + 1;
    localparam int SW = IDXW + 2;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_REPEAT, S_ERROR} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] index_q, index_d;
    logic [CW-1:0]   rep_left_q, rep_left_d;
    logic [BLW-1:0]  rep_val_q, rep_val_d;
    logic [IDXW-1:0] num_bl_q, num_bl_d;
    logic            fmt_q, fmt_d;
    logic [BLW-1:0]  prev_bl_q, prev_bl_d;
    logic [BLW-1:0]  prev_nz_q, prev_nz_d;
    logic            wr_en_q, wr_en_d;
    logic [IDXW-1:0] wr_addr_q, wr_addr_d;
    logic [BLW-1:0]  wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    // Last write has been issued; done fires on the following cycle.
    logic            fin_q, fin_d;

    logic [2:0]      n_bits;
    logic [6:0]      x_mask;
    logic [6:0]      x_val;
    logic [CW-1:0]   count;
    logic [SW-1:0]   end_idx;
    logic            bad_code;
    logic            do_wr;
    logic [BLW-1:0]  wr_val;

    // Decode the extra-bit field and the resulting repeat count for the current code.
    always_comb begin
        n_bits = 3'd0;
        x_mask = 7'h00;
        case (dec_extra_i)
            2'd0: begin n_bits = 3'd0; x_mask = 7'h00; end
            2'd1: begin n_bits = 3'd2; x_mask = 7'h03; end
            2'd2: begin n_bits = 3'd3; x_mask = 7'h07; end
            default: begin n_bits = 3'd7; x_mask = 7'h7f; end
        endcase
        x_val    = 7'(bits_data_i >> dec_len_i) & x_mask;
        count    = CW'(dec_base_i) + CW'(x_val);
        end_idx  = SW'(index_q) + SW'(count);
        bad_code = dec_err_i
                || (end_idx > SW'(num_bl_q))
                || (dec_prev_rep_i && fmt_q && (index_q == '0));
    end

    // Next-state, write generation and the combinational consume count.
    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        rep_left_d     = rep_left_q;
        rep_val_d      = rep_val_q;
        num_bl_d       = num_bl_q;
        fmt_d          = fmt_q;
        prev_bl_d      = prev_bl_q;
        prev_nz_d      = prev_nz_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        done_d         = 1'b0;
        err_d          = err_q;
        fin_d          = 1'b0;
        bits_consume_o = 5'd0;
        do_wr          = 1'b0;
        wr_val         = '0;

        if (start_i) begin
            // start overrides whatever is in flight, including a pending write.
            index_d    = '0;
            rep_left_d = '0;
            prev_bl_d  = '0;
            prev_nz_d  = '0;
            err_d      = 1'b0;
            num_bl_d   = num_bl_i;
            fmt_d      = fmt_deflate_i;
            if (num_bl_i == '0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = S_DECODE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_d = fin_q;
                end
                S_DECODE: begin
                    if (bits_valid_i) begin
                        if (bad_code) begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end else begin
                            bits_consume_o = 5'(dec_len_i) + 5'(n_bits);
                            do_wr          = 1'b1;
                            wr_val         = dec_bl_i;
                            if (count > CW'(1)) begin
                                rep_left_d = count - CW'(1);
                                rep_val_d  = dec_bl_i;
                                state_d    = S_REPEAT;
                            end
                        end
                    end
                end
                S_REPEAT: begin
                    do_wr      = 1'b1;
                    wr_val     = rep_val_q;
                    rep_left_d = rep_left_q - CW'(1);
                    if (rep_left_q == CW'(1)) begin
                        state_d = S_DECODE;
                    end
                end
                default: begin
                end
            endcase

            if (do_wr) begin
                wr_en_d   = 1'b1;
                wr_addr_d = index_q;
                wr_data_d = wr_val;
                index_d   = index_q + IDXW'(1);
                prev_bl_d = wr_val;
                if (wr_val != '0) begin
                    prev_nz_d = wr_val;
                end
                // Overflow is rejected up front, so the last write of a code
                // lands exactly on num_bl when the table is complete.
                if ((CW'(index_q) + CW'(1)) == CW'(num_bl_q)) begin
                    state_d = S_IDLE;
                    fin_d   = 1'b1;
                end
            end
        end

        busy_d = (state_d == S_DECODE) || (state_d == S_REPEAT) || fin_d;
    end

    // State and registered outputs; rst drops everything back to idle at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            rep_left_q <= '0;
            rep_val_q  <= '0;
            num_bl_q   <= '0;
            fmt_q      <= 1'b0;
            prev_bl_q  <= '0;
            prev_nz_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            rep_left_q <= rep_left_d;
            rep_val_q  <= rep_val_d;
            num_bl_q   <= num_bl_d;
            fmt_q      <= fmt_d;
            prev_bl_q  <= prev_bl_d;
            prev_nz_q  <= prev_nz_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fin_q      <= fin_d;
        end
    end

    assign prev_bl_o    = prev_bl_q;
    assign prev_nz_bl_o = prev_nz_q;
    assign bl_wr_en_o   = wr_en_q;
    assign bl_wr_addr_o = wr_addr_q;
    assign bl_wr_data_o = wr_data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
